cla_pipe_adder: RTL and testbench

Parametrised, two-stage pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups and a second lookahead level across groups. Used as the ALU's add/sub datapath. Operands enter through a valid/ready handshake and results leave through one, with full backpressure. Carry-out, signed overflow and zero flags are produced alongside each sum.

---
 rtl/cla_pipe_adder_if.sv | 35 +++
 rtl/cla_pipe_adder.sv | 170 +++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_adder_if.sv
// ============================================================================
// Module  : cla_pipe_adder_if
// Purpose : Operand/result valid-ready bundle for the pipelined CLA adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cla_pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

`default_nettype wire

// File: rtl/cla_pipe_adder.sv
// ============================================================================
// Module  : cla_pipe_adder
// Purpose : Two-stage pipelined carry-lookahead add/sub with valid/ready flow
//           control. Define CLA_PIPE_FLAGS_EN to build the ovf/zero flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_pipe_adder #(
    parameter int WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    cla_pipe_adder_if.slave   bus
);
    localparam int NUM_GRP = WIDTH / 4;
    localparam int NUM_SG  = (NUM_GRP + 3) / 4;

    // Carry into position n of a 4-wide lookahead block, flat sum-of-products.
    function automatic logic la_carry(input logic [3:0] g, input logic [3:0] p,
                                      input logic c0, input int n);
        logic c;
        logic t;
        c = 1'b0;
        for (int m = 0; m < 4; m++) begin
            if (m < n) begin
                t = g[m];
                for (int k = m + 1; k < 4; k++) if (k < n) t = t & p[k];
                c = c | t;
            end
        end
        t = c0;
        for (int k = 0; k < 4; k++) if (k < n) t = t & p[k];
        return c | t;
    endfunction

    logic               v1_q, v1_d, v2_q, v2_d;
    logic               w_adv2, w_acc, w_in_ready;
    logic [WIDTH-1:0]   w_b_eff, w_g, w_p;
    logic [NUM_GRP-1:0] w_gg, w_gp;
    logic               w_cin;

    logic [WIDTH-1:0]   p1_q, g1_q;
    logic [NUM_GRP-1:0] gg1_q, gp1_q;
    logic               cin1_q;

    logic [4*NUM_SG-1:0] w_ggp, w_gpp;
    logic [NUM_SG-1:0]   w_sg, w_sp, w_sc;
    logic [3:0]          w_sgp, w_spp;
    logic [NUM_GRP-1:0]  w_gc;
    logic [WIDTH-1:0]    w_c, w_sum;
    logic                w_cout;

    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    assign w_adv2     = v1_q & (~v2_q | bus.out_ready);
    assign w_in_ready = ~v1_q | w_adv2;
    assign w_acc      = bus.in_valid & w_in_ready;

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        if (w_acc)                    v1_d = 1'b1;
        else if (w_adv2)              v1_d = 1'b0;
        if (w_adv2)                   v2_d = 1'b1;
        else if (bus.out_ready)       v2_d = 1'b0;
    end

    assign w_b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign w_g     = bus.in_a & w_b_eff;
    assign w_p     = bus.in_a ^ w_b_eff;
    assign w_cin   = bus.in_sub | bus.in_cin;

    for (genvar k = 0; k < NUM_GRP; k++) begin : g_s1_grp
        assign w_gg[k] = la_carry(w_g[4*k +: 4], w_p[4*k +: 4], 1'b0, 4);
        assign w_gp[k] = &w_p[4*k +: 4];
    end

    // Padding groups propagate (P=1, G=0) so the top super-group still passes carries.
    if (4*NUM_SG > NUM_GRP) begin : g_grp_pad
        assign w_ggp = {{(4*NUM_SG-NUM_GRP){1'b0}}, gg1_q};
        assign w_gpp = {{(4*NUM_SG-NUM_GRP){1'b1}}, gp1_q};
    end else begin : g_grp_nopad
        assign w_ggp = gg1_q;
        assign w_gpp = gp1_q;
    end

    if (NUM_SG < 4) begin : g_sg_pad
        assign w_sgp = {{(4-NUM_SG){1'b0}}, w_sg};
        assign w_spp = {{(4-NUM_SG){1'b1}}, w_sp};
    end else begin : g_sg_nopad
        assign w_sgp = w_sg;
        assign w_spp = w_sp;
    end

    for (genvar s = 0; s < NUM_SG; s++) begin : g_sg
        assign w_sg[s] = la_carry(w_ggp[4*s +: 4], w_gpp[4*s +: 4], 1'b0, 4);
        assign w_sp[s] = &w_gpp[4*s +: 4];
        assign w_sc[s] = la_carry(w_sgp, w_spp, cin1_q, s);
    end

    for (genvar k = 0; k < NUM_GRP; k++) begin : g_gc
        assign w_gc[k] = la_carry(w_ggp[4*(k/4) +: 4], w_gpp[4*(k/4) +: 4], w_sc[k/4], k % 4);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bc
        assign w_c[i] = la_carry(g1_q[4*(i/4) +: 4], p1_q[4*(i/4) +: 4], w_gc[i/4], i % 4);
    end

    assign w_cout = la_carry(w_sgp, w_spp, cin1_q, NUM_SG);
    assign w_sum  = p1_q ^ w_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            p1_q   <= '0;
            g1_q   <= '0;
            gg1_q  <= '0;
            gp1_q  <= '0;
            cin1_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            // Per-bit generates are kept too: intra-group carries need them.
            if (w_acc) begin
                p1_q   <= w_p;
                g1_q   <= w_g;
                gg1_q  <= w_gg;
                gp1_q  <= w_gp;
                cin1_q <= w_cin;
            end
            if (w_adv2) begin
                sum_q  <= w_sum;
                cout_q <= w_cout;
            end
        end
    end

`ifdef CLA_PIPE_FLAGS_EN
    logic ovf_q, zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (w_adv2) begin
            ovf_q  <= w_c[WIDTH-1] ^ w_cout;
            zero_q <= (w_sum == '0);
        end
    end

    assign bus.out_ovf  = ovf_q;
    assign bus.out_zero = zero_q;
`else
    assign bus.out_ovf  = 1'b0;
    assign bus.out_zero = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = v2_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
// ============================================================================
// Module  : tb_cla_pipe_adder
// Purpose : Self-checking bench for cla_pipe_adder (WIDTH=32) with an
//           arithmetic reference model; honours CLA_PIPE_FLAGS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_pipe_adder;
    localparam int W = 32;
`ifdef CLA_PIPE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(W)) bus();
    cla_pipe_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic cin);
        res_t        r;
        longint      sa, sb, s;
        longint unsigned u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            r.sum  = a - b;
            r.cout = (a >= b);
            s      = sa - sb;
        end else begin
            u      = longint'(a) + longint'(b) + longint'(cin);
            r.sum  = a + b + {31'd0, cin};
            r.cout = (u > 64'hFFFF_FFFF);
            s      = sa + sb + longint'(cin);
        end
        r.ovf  = FLAGS & ((s > 64'sd2147483647) || (s < -64'sd2147483648));
        r.zero = FLAGS & (r.sum == 32'd0);
        return r;
    endfunction

    task automatic drive_cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic cin, input logic ordy,
                               output logic fin, output logic fout, output res_t obs);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sub    = sub;
        bus.in_cin    = cin;
        bus.out_ready = ordy;
        #1;
        fin      = bus.in_valid & bus.in_ready;
        fout     = bus.out_valid & bus.out_ready;
        obs.sum  = bus.out_sum;
        obs.cout = bus.out_cout;
        obs.ovf  = bus.out_ovf;
        obs.zero = bus.out_zero;
    endtask

    // One beat into an empty pipe with out_ready high; reports cycles to output.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic cin, output logic acc, output int lat, output res_t o);
        logic fi, fo;
        drive_cycle(1'b1, a, b, sub, cin, 1'b1, acc, fo, o);
        lat = 0;
        fo  = 1'b0;
        while (!fo && lat < 8) begin
            drive_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, fi, fo, o);
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_sum !== 32'd0) begin bad++; $display("FAIL rst_sum got=%h exp=0", bus.out_sum); end
        total++; if ({bus.out_cout, bus.out_ovf, bus.out_zero} !== 3'b000) begin bad++;
            $display("FAIL rst_flags got=%b%b%b exp=000", bus.out_cout, bus.out_ovf, bus.out_zero); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_carry_ripple();
        logic acc; int lat; res_t o;
        run_one(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, acc, lat, o);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL ripple_accept got=%b exp=1", acc); end
        total++; if (lat != 2) begin bad++; $display("FAIL ripple_latency got=%0d exp=2", lat); end
        total++; if (o.sum !== 32'h0) begin bad++; $display("FAIL ripple_sum got=%h exp=0", o.sum); end
        total++; if (o.cout !== 1'b1) begin bad++; $display("FAIL ripple_cout got=%b exp=1", o.cout); end
        total++; if (o.ovf !== 1'b0) begin bad++; $display("FAIL ripple_ovf got=%b exp=0", o.ovf); end
        total++; if (o.zero !== FLAGS) begin bad++; $display("FAIL ripple_zero got=%b exp=%b", o.zero, FLAGS); end
    endtask

    task automatic test_sub_ovf();
        logic acc; int lat; res_t o;
        run_one(32'h8000_0000, 32'h1, 1'b1, 1'b0, acc, lat, o);
        total++; if (o.sum !== 32'h7FFF_FFFF) begin bad++; $display("FAIL subovf_sum got=%h exp=7fffffff", o.sum); end
        total++; if (o.cout !== 1'b1) begin bad++; $display("FAIL subovf_cout got=%b exp=1", o.cout); end
        total++; if (o.ovf !== FLAGS) begin bad++; $display("FAIL subovf_ovf got=%b exp=%b", o.ovf, FLAGS); end
        total++; if (o.zero !== 1'b0) begin bad++; $display("FAIL subovf_zero got=%b exp=0", o.zero); end
    endtask

    task automatic test_flags();
        logic acc; int lat; res_t o;
        run_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, acc, lat, o);
        total++; if (o.sum !== 32'h8000_0000) begin bad++; $display("FAIL flags_sum got=%h exp=80000000", o.sum); end
        total++; if (o.cout !== 1'b0) begin bad++; $display("FAIL flags_cout got=%b exp=0", o.cout); end
        total++; if (o.ovf !== FLAGS) begin bad++; $display("FAIL flags_ovf got=%b exp=%b", o.ovf, FLAGS); end
        total++; if (o.zero !== 1'b0) begin bad++; $display("FAIL flags_zero got=%b exp=0", o.zero); end
        // in_cin must be ignored when subtracting
        run_one(32'h5, 32'h5, 1'b1, 1'b1, acc, lat, o);
        total++; if ({o.sum, o.cout, o.ovf, o.zero} !== {32'h0, 1'b1, 1'b0, FLAGS}) begin bad++;
            $display("FAIL flags_sub_zero got=%h/%b%b%b exp=0/10%b", o.sum, o.cout, o.ovf, o.zero, FLAGS); end
    endtask

    task automatic test_backpressure();
        logic fi, fo; res_t o; int idx, got;
        logic [31:0] exp_s [3];
        exp_s[0] = 32'd3; exp_s[1] = 32'd7; exp_s[2] = 32'd11;
        idx = 0; got = 0;
        for (int c = 0; c < 5; c++) begin
            drive_cycle(idx < 3, 32'(2*idx+1), 32'(2*idx+2), 1'b0, 1'b0, 1'b0, fi, fo, o);
            if (fi) idx++;
            if (bus.out_valid) begin
                total++; if (o.sum !== 32'd3) begin bad++; $display("FAIL bp_stall_hold cyc=%0d got=%h exp=3", c, o.sum); end
            end
        end
        total++; if (idx != 2) begin bad++; $display("FAIL bp_accepts got=%0d exp=2", idx); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
        for (int c = 0; c < 12 && got < 3; c++) begin
            drive_cycle(idx < 3, 32'(2*idx+1), 32'(2*idx+2), 1'b0, 1'b0, 1'b1, fi, fo, o);
            if (fi) idx++;
            if (fo) begin
                total++; if (o.sum !== exp_s[got]) begin bad++; $display("FAIL bp_order idx=%0d got=%h exp=%h", got, o.sum, exp_s[got]); end
                got++;
            end
        end
        total++; if (got != 3 || idx != 3) begin bad++; $display("FAIL bp_count got=%0d/%0d exp=3/3", got, idx); end
    endtask

    task automatic test_stream();
        logic fi, fo; res_t o, e;
        logic [31:0] a, b; logic sub, cin, ordy;
        int sent, recv, cyc, acc_run, out_run;
        exp_q.delete();
        sent = 0; recv = 0; cyc = 0;
        while (recv < 16 && cyc < 300) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1)); ordy = 1'($urandom_range(0, 1));
            drive_cycle(sent < 16, a, b, sub, cin, ordy, fi, fo, o);
            if (fi) begin exp_q.push_back(model(a, b, sub, cin)); sent++; end
            if (fo) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                total++; if (o !== e) begin bad++;
                    $display("FAIL stream_rand n=%0d got=%h/%b%b%b exp=%h/%b%b%b", recv, o.sum, o.cout, o.ovf, o.zero, e.sum, e.cout, e.ovf, e.zero); end
                recv++;
            end
            cyc++;
        end
        total++; if (recv != 16) begin bad++; $display("FAIL stream_rand_count got=%0d exp=16", recv); end
        recv = 0; acc_run = 0; out_run = 0;
        for (int c = 0; c < 18; c++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            drive_cycle(c < 16, a, b, sub, cin, 1'b1, fi, fo, o);
            if (fi) begin exp_q.push_back(model(a, b, sub, cin)); acc_run++; end
            if (fo) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                total++; if (o !== e) begin bad++;
                    $display("FAIL stream_full n=%0d got=%h/%b%b%b exp=%h/%b%b%b", recv, o.sum, o.cout, o.ovf, o.zero, e.sum, e.cout, e.ovf, e.zero); end
                recv++;
                if (c >= 2 && c < 16) out_run++;
            end
        end
        total++; if (acc_run != 16) begin bad++; $display("FAIL stream_rate_in got=%0d exp=16", acc_run); end
        total++; if (out_run != 14 || recv != 16) begin bad++; $display("FAIL stream_rate_out got=%0d/%0d exp=14/16", out_run, recv); end
    endtask

    task automatic test_async_reset();
        logic fi, fo, acc; res_t o; int lat;
        drive_cycle(1'b1, 32'd10, 32'd20, 1'b0, 1'b0, 1'b0, fi, fo, o);
        drive_cycle(1'b1, 32'd30, 32'd40, 1'b0, 1'b0, 1'b0, fi, fo, o);
        drive_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, fi, fo, o);
        total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin bad++;
            $display("FAIL arst_full got=%b%b exp=10", bus.out_valid, bus.in_ready); end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_sum !== 32'd0) begin bad++; $display("FAIL arst_sum got=%h exp=0", bus.out_sum); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b exp=1", bus.in_ready); end
        @(posedge clk);
        #2 rst = 1'b0;
        run_one(32'd5, 32'd3, 1'b1, 1'b0, acc, lat, o);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL arst_first_accept got=%b exp=1", acc); end
        total++; if (o.sum !== 32'd2 || o.cout !== 1'b1 || lat != 2) begin bad++;
            $display("FAIL arst_after got=%h/%b lat=%0d exp=2/1 lat=2", o.sum, o.cout, lat); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_carry_ripple();
        test_sub_ovf();
        test_flags();
        test_backpressure();
        test_stream();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
